// File: rtl/led_strip_pkg.sv
// Shared types and frame constants for the APA102-style LED strip SPI driver.
// The end-frame length grows with the chain so the clock edge reaches the last LED.
package led_strip_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START_FR = 2'd1,
    LED_FR   = 2'd2,
    END_FR   = 2'd3
  } state_t;

  localparam int START_BITS = 32;
  localparam int WORD_BITS  = 32;
  localparam logic [2:0] LED_HDR = 3'b111;

  function automatic int end_bits(input int num_leds);
    return 8 * ((num_leds + 15) / 16);
  endfunction

endpackage

// File: rtl/spi_bit_tx.sv
// Bit-level serialiser: CLK_DIV-cycle sck half-periods, MSB-first 32-bit shifter.
// bit_done marks the last cycle of each bit so the FSM can reload a word seamlessly.
module spi_bit_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        stop,
  input  logic        fill,
  output logic        bit_done,
  output logic        sck,
  output logic        mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             phase_r;
  logic             active_r;
  logic [31:0]      shift_r;

  // sck and mosi come straight from registers; both are cleared whenever the line is idle
  assign sck      = phase_r;
  assign mosi     = shift_r[31];
  assign bit_done = active_r && phase_r && (div_cnt_r == DIV_LAST);

  // Divider, phase and shift register sequencing
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      div_cnt_r <= {DIV_W{1'b0}};
      phase_r   <= 1'b0;
      active_r  <= 1'b0;
      shift_r   <= 32'h0;
    end else if (load) begin
      div_cnt_r <= {DIV_W{1'b0}};
      phase_r   <= 1'b0;
      active_r  <= 1'b1;
      shift_r   <= load_data;
    end else if (active_r) begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= {DIV_W{1'b0}};
        phase_r   <= ~phase_r;
        // the data edge coincides with the falling sck edge
        if (phase_r) begin
          shift_r <= {shift_r[30:0], fill};
        end else begin
          shift_r <= shift_r;
        end
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

endmodule

// File: rtl/led_strip_spi.sv
// Frame sequencer for an LED strip: start frame, one word per LED fetched from pixel RAM,
// then a run of one-bits long enough to clock data through the whole chain.
module led_strip_spi
  import led_strip_pkg::*;
#(
  parameter int NUM_LEDS      = 60,
  parameter int CLK_DIV       = 4,
  parameter int GLOBAL_BRIGHT = 0,
  localparam int IDX_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             CLK,
  input  logic             my_reset,
  input  logic             start,
  input  logic [4:0]       gbright,
  output logic             pix_req,
  output logic [IDX_W-1:0] pix_idx,
  input  logic [28:0]      pix_data,
  output logic             busy,
  output logic             done,
  output logic             sck,
  output logic             mosi
);

  localparam int END_N    = end_bits(NUM_LEDS);
  localparam int MAX_BITS = (END_N > WORD_BITS) ? END_N : WORD_BITS;
  localparam int BIT_W    = $clog2(MAX_BITS);
  localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_BITS - 1);
  localparam logic [BIT_W-1:0] REQ_BIT   = BIT_W'(WORD_BITS - 2);
  localparam logic [BIT_W-1:0] END_LAST  = BIT_W'(END_N - 1);
  localparam logic [IDX_W-1:0] LED_LAST  = IDX_W'(NUM_LEDS - 1);

  state_t           state_r, state_nx;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [IDX_W-1:0] led_cnt_r, pix_idx_r;
  logic [4:0]       gbright_r;
  logic [28:0]      pix_hold_r, pix_cur_s;
  logic             pix_req_r, pix_req_d_r, busy_r, done_r;
  logic             load_s, stop_s, req_s, accept_s, fill_s, bit_done_s;
  logic             word_end_s, req_bit_s, last_led_s;
  logic [4:0]       bright_s;
  logic [31:0]      load_word_s, led_word_s;

  assign pix_req = pix_req_r;
  assign pix_idx = pix_idx_r;
  assign busy    = busy_r;
  assign done    = done_r;

  // RAM data is valid only in the cycle after pix_req; bypass the hold register for it
  assign pix_cur_s  = pix_req_d_r ? pix_data : pix_hold_r;
  assign bright_s   = (GLOBAL_BRIGHT != 0) ? gbright_r : pix_cur_s[28:24];
  assign led_word_s = {LED_HDR, bright_s, pix_cur_s[23:0]};
  assign word_end_s = bit_done_s && (bit_cnt_r == WORD_LAST);
  assign req_bit_s  = bit_done_s && (bit_cnt_r == REQ_BIT);
  assign last_led_s = (led_cnt_r == LED_LAST);

  spi_bit_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk      (CLK),
    .rst      (my_reset),
    .load     (load_s),
    .load_data(load_word_s),
    .stop     (stop_s),
    .fill     (fill_s),
    .bit_done (bit_done_s),
    .sck      (sck),
    .mosi     (mosi)
  );

  // Next-state and word-load decisions
  always_comb begin
    state_nx    = state_r;
    load_s      = 1'b0;
    load_word_s = 32'h0;
    stop_s      = 1'b0;
    req_s       = 1'b0;
    accept_s    = 1'b0;
    fill_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // a start coinciding with done is dropped
        if (start && !done_r) begin
          accept_s = 1'b1;
          load_s   = 1'b1;
          state_nx = START_FR;
        end else begin
          state_nx = IDLE;
        end
      end
      START_FR: begin
        if (word_end_s) begin
          load_s      = 1'b1;
          load_word_s = led_word_s;
          state_nx    = LED_FR;
        end else begin
          req_s = req_bit_s;
        end
      end
      LED_FR: begin
        if (word_end_s) begin
          load_s = 1'b1;
          if (last_led_s) begin
            load_word_s = 32'hFFFF_FFFF;
            state_nx    = END_FR;
          end else begin
            load_word_s = led_word_s;
          end
        end else begin
          req_s = req_bit_s && !last_led_s;
        end
      end
      END_FR: begin
        fill_s = 1'b1;
        if (bit_done_s && (bit_cnt_r == END_LAST)) begin
          stop_s   = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = END_FR;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (my_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Counters, pixel handshake and registered status outputs
  always_ff @(posedge CLK) begin
    if (my_reset) begin
      bit_cnt_r   <= {BIT_W{1'b0}};
      led_cnt_r   <= {IDX_W{1'b0}};
      pix_idx_r   <= {IDX_W{1'b0}};
      gbright_r   <= 5'h0;
      pix_hold_r  <= 29'h0;
      pix_req_r   <= 1'b0;
      pix_req_d_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r      <= (state_nx != IDLE);
      done_r      <= stop_s;
      pix_req_r   <= req_s;
      pix_req_d_r <= pix_req_r;
      if (load_s || stop_s) begin
        bit_cnt_r <= {BIT_W{1'b0}};
      end else if (bit_done_s) begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
      if (accept_s) begin
        led_cnt_r <= {IDX_W{1'b0}};
        gbright_r <= gbright;
      end else if ((state_r == LED_FR) && word_end_s && !last_led_s) begin
        led_cnt_r <= led_cnt_r + IDX_W'(1);
      end
      if (req_s) begin
        pix_idx_r <= (state_r == START_FR) ? {IDX_W{1'b0}} : led_cnt_r + IDX_W'(1);
      end
      if (pix_req_d_r) begin
        pix_hold_r <= pix_data;
      end
    end
  end

endmodule
